// File: rtl/airlock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : airlock_pkg
// Purpose  : Shared state encoding, timer width and default timing limits
//            for the airlock pressurization sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package airlock_pkg;

    localparam int                 c_TIMER_W           = 8;
    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX       = 8'd255;

    localparam int                 c_ACK_WAIT_DEF      = 4;
    localparam int                 c_MAX_PRESS_DEF     = 8;
    localparam int                 c_UNLOCK_CYCLES_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_PRESS  = 3'd2,
        ST_UNLOCK = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

endpackage : airlock_pkg
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Purpose  : Saturating per-state cycle timer with synchronous clear and a
//            terminal flag raised during the last cycle before i_limit.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_timer
    import airlock_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [c_TIMER_W-1:0] i_limit,
    output logic                 o_hit
);

    logic [c_TIMER_W-1:0] r_count;

    // Count cycles spent in the current state; stop at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_TIMER_MAX)) begin
            r_count <= r_count + c_TIMER_W'(1);
        end
    end

    // Hit in the cycle whose closing edge makes the elapsed count reach i_limit.
    assign o_hit = (r_count >= (i_limit - c_TIMER_W'(1)));

endmodule : cycle_timer
`default_nettype wire

// File: rtl/airlock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : airlock_sequencer
// Purpose  : Sequences an airlock pressurization cycle: request, pressurizer
//            handshake with timeouts, timed inner-door release, sticky fault.
// Revision : 1.0 - initial release
// ============================================================================
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int unsigned ACK_WAIT      = c_ACK_WAIT_DEF,
    parameter int unsigned MAX_PRESS     = c_MAX_PRESS_DEF,
    parameter int unsigned UNLOCK_CYCLES = c_UNLOCK_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cycle_req,
    input  logic       door_closed,
    input  logic       pressurizing,
    input  logic       fault_clr,
    output logic       start,
    output logic       inner_unlock,
    output logic       busy,
    output logic       done,
    output logic       reject,
    output logic       fault,
    output logic [7:0] cycle_count
);

    localparam logic [c_TIMER_W-1:0] c_ACK_LIM    = c_TIMER_W'(ACK_WAIT);
    localparam logic [c_TIMER_W-1:0] c_PRESS_LIM  = c_TIMER_W'(MAX_PRESS);
    localparam logic [c_TIMER_W-1:0] c_UNLOCK_LIM = c_TIMER_W'(UNLOCK_CYCLES);

    state_t               r_state;
    state_t               w_next;
    logic [c_TIMER_W-1:0] w_limit;
    logic                 w_hit;
    logic                 w_tmr_clear;
    logic                 w_tmr_en;
    logic                 w_reject_d;
    logic                 w_done_d;

    logic                 r_start;
    logic                 r_unlock;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_reject;
    logic                 r_fault;
    logic [7:0]           r_cycle_count;

    // Select the timeout limit that applies to the current state.
    always_comb begin
        w_limit = c_TIMER_MAX;
        case (r_state)
            ST_START:  w_limit = c_ACK_LIM;
            ST_PRESS:  w_limit = c_PRESS_LIM;
            ST_UNLOCK: w_limit = c_UNLOCK_LIM;
            default:   w_limit = c_TIMER_MAX;
        endcase
    end

    assign w_tmr_clear = (w_next != r_state);
    assign w_tmr_en    = (r_state != ST_IDLE);

    cycle_timer u_timer (
        .clk      (clock),
        .rst_n    (reset),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_en),
        .i_limit  (w_limit),
        .o_hit    (w_hit)
    );

    // Next-state logic; door breach in PRESS outranks completion.
    always_comb begin
        w_next     = r_state;
        w_reject_d = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cycle_req) begin
                    if (door_closed) w_next = ST_START;
                    else             w_reject_d = 1'b1;
                end
            end
            ST_START: begin
                if (pressurizing) w_next = ST_PRESS;
                else if (w_hit)   w_next = ST_FAULT;
            end
            ST_PRESS: begin
                if (!door_closed)       w_next = ST_FAULT;
                else if (!pressurizing) w_next = ST_UNLOCK;
                else if (w_hit)         w_next = ST_FAULT;
            end
            ST_UNLOCK: begin
                if (w_hit) w_next = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr && !pressurizing) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        w_done_d = (r_state == ST_PRESS) && (w_next == ST_UNLOCK);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start       <= 1'b0;
            r_unlock      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_reject      <= 1'b0;
            r_fault       <= 1'b0;
            r_cycle_count <= 8'd0;
        end else begin
            r_start  <= (w_next == ST_START);
            r_unlock <= (w_next == ST_UNLOCK);
            r_busy   <= (w_next != ST_IDLE);
            r_done   <= w_done_d;
            r_reject <= w_reject_d;
            r_fault  <= (w_next == ST_FAULT);
            if (w_done_d) r_cycle_count <= r_cycle_count + 8'd1;
        end
    end

    assign start        = r_start;
    assign inner_unlock = r_unlock;
    assign busy         = r_busy;
    assign done         = r_done;
    assign reject       = r_reject;
    assign fault        = r_fault;
    assign cycle_count  = r_cycle_count;

endmodule : airlock_sequencer
`default_nettype wire

// File: tb/tb_airlock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_airlock_sequencer
// Purpose  : Directed self-checking bench for airlock_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_airlock_sequencer;

    logic       clock;
    logic       reset;
    logic       cycle_req;
    logic       door_closed;
    logic       pressurizing;
    logic       fault_clr;
    logic       start;
    logic       inner_unlock;
    logic       busy;
    logic       done;
    logic       reject;
    logic       fault;
    logic [7:0] cycle_count;

    int n_run;
    int n_fail;

    airlock_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .cycle_req    (cycle_req),
        .door_closed  (door_closed),
        .pressurizing (pressurizing),
        .fault_clr    (fault_clr),
        .start        (start),
        .inner_unlock (inner_unlock),
        .busy         (busy),
        .done         (done),
        .reject       (reject),
        .fault        (fault),
        .cycle_count  (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output vector order: {start, inner_unlock, busy, done, reject, fault}
    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, start, inner_unlock, busy, done, reject, fault}, {26'd0, exp});
    endtask

    // Full checked cycle: pressurizing seen 2 edges after start rises, high 5 samples.
    task automatic normal_cycle(input bit poke, input logic [7:0] exp_cnt);
        cycle_req = 1'b1; door_closed = 1'b1; pressurizing = 1'b0;
        tick(); chk_out("start_entry", 6'b101000);
        cycle_req = 1'b0;
        tick(); chk_out("start_hold", 6'b101000);
        pressurizing = 1'b1;
        tick(); chk_out("press_entry", 6'b001000);
        if (poke) cycle_req = 1'b1;
        repeat (3) tick();
        chk_out("press_mid", 6'b001000);
        tick();
        cycle_req = 1'b0; pressurizing = 1'b0;
        tick(); chk_out("unlock_entry", 6'b011100);
        chk("count_done", {24'd0, cycle_count}, {24'd0, exp_cnt});
        tick(); chk_out("unlock_2", 6'b011000);
        tick(); chk_out("unlock_3", 6'b011000);
        tick(); chk_out("idle_back", 6'b000000);
    endtask

    // Unchecked minimal successful cycle used to advance the counter.
    task automatic fast_cycle();
        cycle_req = 1'b1; door_closed = 1'b1;
        tick();
        cycle_req = 1'b0; pressurizing = 1'b1;
        tick();
        tick();
        pressurizing = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        reset = 1'b0; cycle_req = 1'b0; door_closed = 1'b0;
        pressurizing = 1'b0; fault_clr = 1'b0;

        // Reset state
        tick(); tick();
        chk_out("reset_outs", 6'b000000);
        chk("reset_count", {24'd0, cycle_count}, 32'd0);
        reset = 1'b1;

        // Normal cycle, then a cycle with a stray request during PRESS
        normal_cycle(1'b0, 8'd1);
        normal_cycle(1'b1, 8'd2);

        // Acknowledge timeout
        cycle_req = 1'b1; door_closed = 1'b1; pressurizing = 1'b0;
        tick(); chk_out("ack_start", 6'b101000);
        cycle_req = 1'b0;
        repeat (3) tick();
        chk_out("ack_start_4th", 6'b101000);
        tick(); chk_out("ack_fault", 6'b001001);
        pressurizing = 1'b1; fault_clr = 1'b1;
        tick(); chk_out("fault_hold_press", 6'b001001);
        pressurizing = 1'b0;
        tick(); chk_out("fault_cleared", 6'b000000);
        fault_clr = 1'b0;

        // Door breach coinciding with completion: breach wins
        cycle_req = 1'b1; door_closed = 1'b1;
        tick();
        cycle_req = 1'b0; pressurizing = 1'b1;
        tick(); chk_out("breach_press", 6'b001000);
        door_closed = 1'b0; pressurizing = 1'b0;
        tick(); chk_out("breach_fault", 6'b001001);
        chk("breach_count", {24'd0, cycle_count}, 32'd2);
        fault_clr = 1'b1;
        tick(); chk_out("breach_clr", 6'b000000);
        fault_clr = 1'b0;

        // Rejection with open door
        cycle_req = 1'b1;
        tick(); chk_out("reject_pulse", 6'b000010);
        cycle_req = 1'b0;
        tick(); chk_out("reject_end", 6'b000000);

        // Asynchronous reset in PRESS
        cycle_req = 1'b1; door_closed = 1'b1;
        tick();
        cycle_req = 1'b0; pressurizing = 1'b1;
        tick(); chk_out("pre_rst_press", 6'b001000);
        #2 reset = 1'b0;
        #1 chk_out("rst_async_press", 6'b000000);
        chk("rst_async_count", {24'd0, cycle_count}, 32'd0);
        pressurizing = 1'b0;
        tick();
        reset = 1'b1;

        // Asynchronous reset in UNLOCK drops inner_unlock
        cycle_req = 1'b1;
        tick();
        cycle_req = 1'b0; pressurizing = 1'b1;
        tick();
        pressurizing = 1'b0;
        tick(); chk_out("pre_rst_unlock", 6'b011100);
        #2 reset = 1'b0;
        #1 chk_out("rst_async_unlock", 6'b000000);
        tick();
        reset = 1'b1;

        // Counter wrap
        for (int i = 0; i < 255; i++) fast_cycle();
        chk("count_255", {24'd0, cycle_count}, 32'd255);
        normal_cycle(1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_airlock_sequencer
`default_nettype wire
